// File: rtl/serial_adder_pkg.sv
// Shared types for the serial adder datapath: capture FSM states and index sizing.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CARRY = 2'd2,
    HOLD  = 2'd3
  } sumcap_state_t;

  // Bits needed to hold a bit index that can reach WIDTH (one past the last sum bit).
  function automatic int idx_width(input int width);
    return (width < 1) ? 1 : $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sumcap_bit_counter.sv
// Bit index counter for the sum capture stage, with clear, enable and terminal count.
// Latency: idx updates on the edge after clear/en; term is combinational from idx.
// Backpressure: none; the caller stalls it by holding en low.
module sumcap_bit_counter
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IW    = idx_width(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          en,
  output logic [IW-1:0] idx,
  output logic          term
);

  // Clear wins over enable so a restart never inherits a stale index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (en) begin
      idx <= idx + IW'(1);
    end
  end

  // Terminal count marks the last sum bit; incrementing past it leaves idx at WIDTH.
  assign term = (idx == IW'(WIDTH - 1));

endmodule

// File: rtl/serial_sum_capture.sv
// Collects WIDTH serial sum bits LSB-first plus the final carry into a (WIDTH+1)-bit word.
// Latency: WIDTH+2 edges from start to result_valid (enter, WIDTH bits, carry).
// Backpressure: result/result_valid hold in HOLD until result_ready; start+ready chains the next word.
// Optional: define SUMCAP_PARITY_EN to add a parity output over the committed word.
module serial_sum_capture
  import serial_adder_pkg::*;
#(
  parameter int   WIDTH = 4,
  localparam int  IW    = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             s,
  input  logic             c,
  output logic [WIDTH:0]   result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy,
  output logic [IW-1:0]    bit_idx
`ifdef SUMCAP_PARITY_EN
  ,
  output logic             parity
`endif
);

  sumcap_state_t      state;
  sumcap_state_t      state_nxt;
  logic [WIDTH-1:0]   shadow;
  logic               cnt_clr;
  logic               cnt_en;
  logic               cnt_term;
  logic               shadow_clr;
  logic               shadow_we;
  logic               commit;
  logic               take;

  sumcap_bit_counter #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clr),
    .en    (cnt_en),
    .idx   (bit_idx),
    .term  (cnt_term)
  );

  // State register; reset mid-word discards the partial word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath strobes; start only counts in IDLE or alongside a HOLD handshake.
  always_comb begin
    state_nxt  = state;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    shadow_clr = 1'b0;
    shadow_we  = 1'b0;
    commit     = 1'b0;
    take       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = SHIFT;
          cnt_clr    = 1'b1;
          shadow_clr = 1'b1;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          shadow_we = 1'b1;
          cnt_en    = 1'b1;
          if (cnt_term) begin
            state_nxt = CARRY;
          end
        end
      end
      CARRY: begin
        if (bit_valid) begin
          commit    = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (result_ready) begin
          take = 1'b1;
          if (start) begin
            state_nxt  = SHIFT;
            cnt_clr    = 1'b1;
            shadow_clr = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Shadow assembly and atomic commit; result only moves on the carry edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow       <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      if (shadow_clr) begin
        shadow <= '0;
      end else if (shadow_we) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (bit_idx == IW'(i)) begin
            shadow[i] <= s;
          end
        end
      end
      if (commit) begin
        result       <= {c, shadow};
        result_valid <= 1'b1;
      end else if (take) begin
        result_valid <= 1'b0;
      end
    end
  end

  assign busy = (state == SHIFT) || (state == CARRY);

`ifdef SUMCAP_PARITY_EN
  // Parity tracks the committed word, so it changes on the same edge as result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity <= 1'b0;
    end else if (commit) begin
      parity <= ^{c, shadow};
    end
  end
`endif

endmodule
